vdp_super_palette: RTL and testbench
====================================

Name: vdp_super_palette

Overview:
- 256-entry, 24-bit RGB palette RAM for the super-res / super-mid display path.
- Sits directly downstream of the super-res pixel fetcher, which drives an 8-bit palette index every clk. This block returns the matching R/G/B bytes one clk later, and those bytes form the high-res colour output.
- The CPU loads entries through a two-port register interface: an index port and a data port. The data port uses an R,G,B byte sequencer with auto-increment.

Parameters:
- IDX_WIDTH, 8, palette index width; the table has 2**IDX_WIDTH entries.
- CH_WIDTH, 8, width of each colour channel.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- palette_addr  in  IDX_WIDTH  index from the super-res fetcher, sampled every clk.
- palette_r  out  CH_WIDTH  red of the entry addressed on the previous clk.
- palette_g  out  CH_WIDTH  green of the entry addressed on the previous clk.
- palette_b  out  CH_WIDTH  blue of the entry addressed on the previous clk.
- reg_wr  in  1  CPU write strobe, one clk per access.
- reg_rd  in  1  CPU read strobe, one clk per access.
- reg_sel  in  1  0 = index port, 1 = data port.
- reg_wdata  in  8  CPU write data.
- reg_rdata  out  8  CPU read data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - palette_r/g/b = 0, reg_rdata = 0.
  - Write index = 0, byte phase = PH_R, staging registers red_hold/green_hold = 0.
  - Palette RAM contents are not cleared by reset; they are undefined until written.
- Video read path:
  - Synchronous RAM read; latency exactly 1 clk.
  - palette_addr = A at edge n gives entry[A] on palette_r/g/b after edge n+1.
  - Outputs update every clk with no stall.
- Index port (reg_wr && reg_sel == 0):
  - index <= reg_wdata[IDX_WIDTH-1:0].
  - phase <= PH_R.
  - red_hold and green_hold are left unchanged but are superseded by the next data writes.
- Data port write state machine (reg_wr && reg_sel == 1):
  - PH_R: red_hold <= reg_wdata; go to PH_G.
  - PH_G: green_hold <= reg_wdata; go to PH_B.
  - PH_B: entry[index] <= {red_hold, green_hold, reg_wdata} in a single RAM write; index <= index + 1 modulo 2**IDX_WIDTH (255 wraps to 0); go to PH_R.
  - Only the PH_B commit modifies RAM. An incomplete R/G sequence never alters an entry.
- Collisions:
  - Commit to entry X in the same clk that palette_addr == X: the video read returns the old value (read-before-write). The new value is visible from the next clk's lookup.
  - reg_wr and reg_rd asserted together: the write is performed and the read is ignored; reg_rdata holds its value.
- Reset mid-sequence: phase returns to PH_R and the partially gathered bytes are discarded; no RAM write occurs.
- Gaps of any length between data-port writes are allowed; phase is held.

Optional Feature:
- Macro: VDP_SUPER_PALETTE_READBACK_EN.
- With it defined:
  - reg_rd && reg_sel == 0: reg_rdata <= current index on the next clk.
  - reg_rd && reg_sel == 1: reg_rdata <= the channel of entry[index] selected by phase (R, G, then B), with latency 1 clk.
  - Reads advance the same phase/index sequencer as writes, including increment and wrap after B.
  - Read-back uses a second RAM read port and never disturbs the video path.
- Without it: reg_rdata is constant 0 and reg_rd has no effect on any state.

Test Plan:
- Reset, write index 0x10, data 0x11, 0x22, 0x33; drive palette_addr = 0x10 -> one clk later palette_r/g/b = 0x11/0x22/0x33. Index is now 0x11 and phase is PH_R.
- Write index 0xFF, data 0x01, 0x02, 0x03, 0x04, 0x05, 0x06 -> entry 0xFF = 010203 and entry 0x00 = 040506 (wrap).
- Entry 0x20 = 000000; hold palette_addr = 0x20 while committing AABBCC to 0x20 -> the output is 000000 on the clk after the commit edge and AABBCC one clk later.
- Write index 0x30, data 0x77, 0x88, then assert reset_n low, release, write index 0x30, data 0x01, 0x02, 0x03 -> entry 0x30 = 010203, and no write of 0x77/0x88 ever reached RAM.
- Index write in the middle of a sequence: write index 0x40, data 0x99, write index 0x41, data 0x0A, 0x0B, 0x0C -> entry 0x41 = 0A0B0C and entry 0x40 is unchanged.
- With VDP_SUPER_PALETTE_READBACK_EN defined: after case 1, write index 0x10 and read data three times -> reg_rdata = 0x11, 0x22, 0x33, and an index read returns 0x11. Without the macro, reg_rdata stays 0.

Source files
------------

// File: rtl/vdp_super_palette.sv
// 256-entry RGB palette RAM for the super-res video path, with a CPU R,G,B byte sequencer.
// Optional read-back of index and entries is enabled by defining VDP_SUPER_PALETTE_READBACK_EN.
module vdp_super_palette #(
  parameter int IDX_WIDTH = 8,
  parameter int CH_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IDX_WIDTH-1:0] palette_addr,
  output logic [CH_WIDTH-1:0]  palette_r,
  output logic [CH_WIDTH-1:0]  palette_g,
  output logic [CH_WIDTH-1:0]  palette_b,
  input  logic                 reg_wr,
  input  logic                 reg_rd,
  input  logic                 reg_sel,
  input  logic [7:0]           reg_wdata,
  output logic [7:0]           reg_rdata
);

  localparam int DEPTH = 2**IDX_WIDTH;

  typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;

  logic [3*CH_WIDTH-1:0] mem [DEPTH];

  phase_t                phase;
  logic [IDX_WIDTH-1:0]  index;
  logic [CH_WIDTH-1:0]   red_hold;
  logic [CH_WIDTH-1:0]   green_hold;

  logic idx_wr;
  logic data_wr;
  logic data_rd;
  logic advance;
  logic commit;

  assign idx_wr  = reg_wr && !reg_sel;
  assign data_wr = reg_wr && reg_sel;
`ifdef VDP_SUPER_PALETTE_READBACK_EN
  // A write in the same clk wins; the read is dropped.
  assign data_rd = reg_rd && !reg_wr && reg_sel;
`else
  assign data_rd = 1'b0;
`endif
  assign advance = data_wr || data_rd;
  assign commit  = data_wr && (phase == PH_B);

  // Video lookup: registered read, old data on a same-clk commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      palette_r <= '0;
      palette_g <= '0;
      palette_b <= '0;
    end else begin
      {palette_r, palette_g, palette_b} <= mem[palette_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[index] <= {red_hold, green_hold, CH_WIDTH'(reg_wdata)};
    end
  end

  // Byte sequencer shared by data-port writes and (optionally) reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase      <= PH_R;
      index      <= '0;
      red_hold   <= '0;
      green_hold <= '0;
    end else if (idx_wr) begin
      index <= IDX_WIDTH'(reg_wdata);
      phase <= PH_R;
    end else if (advance) begin
      case (phase)
        PH_R: begin
          if (data_wr) red_hold <= CH_WIDTH'(reg_wdata);
          phase <= PH_G;
        end
        PH_G: begin
          if (data_wr) green_hold <= CH_WIDTH'(reg_wdata);
          phase <= PH_B;
        end
        PH_B: begin
          index <= index + IDX_WIDTH'(1);
          phase <= PH_R;
        end
        default: phase <= PH_R;
      endcase
    end
  end

`ifdef VDP_SUPER_PALETTE_READBACK_EN
  logic [3*CH_WIDTH-1:0] rb_word;
  logic                  idx_rd;

  assign rb_word = mem[index];
  assign idx_rd  = reg_rd && !reg_wr && !reg_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_rdata <= '0;
    end else if (idx_rd) begin
      reg_rdata <= 8'(index);
    end else if (data_rd) begin
      case (phase)
        PH_R:    reg_rdata <= 8'(rb_word[3*CH_WIDTH-1:2*CH_WIDTH]);
        PH_G:    reg_rdata <= 8'(rb_word[2*CH_WIDTH-1:CH_WIDTH]);
        default: reg_rdata <= 8'(rb_word[CH_WIDTH-1:0]);
      endcase
    end
  end
`else
  logic unused_rd;
  assign unused_rd = reg_rd;
  assign reg_rdata = '0;
`endif

endmodule

// File: tb/tb_vdp_super_palette.sv
// Directed bench for vdp_super_palette: CPU load sequences, wrap, collisions, resets, read-back.
module tb_vdp_super_palette;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] palette_addr = 8'h00;
  logic [7:0] palette_r, palette_g, palette_b;
  logic       reg_wr = 1'b0;
  logic       reg_rd = 1'b0;
  logic       reg_sel = 1'b0;
  logic [7:0] reg_wdata = 8'h00;
  logic [7:0] reg_rdata;

  int vec_count = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl [11];

  logic [23:0] pix;
  assign pix = {palette_r, palette_g, palette_b};

  vdp_super_palette #(.IDX_WIDTH(8), .CH_WIDTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .palette_addr (palette_addr),
    .palette_r    (palette_r),
    .palette_g    (palette_g),
    .palette_b    (palette_b),
    .reg_wr       (reg_wr),
    .reg_rd       (reg_rd),
    .reg_sel      (reg_sel),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  // All drivers start and end on a falling edge.
  task automatic wr(input logic sel, input logic [7:0] d);
    reg_wr    = 1'b1;
    reg_sel   = sel;
    reg_wdata = d;
    @(negedge clk);
    reg_wr    = 1'b0;
  endtask

  task automatic rd(input logic sel);
    reg_rd  = 1'b1;
    reg_sel = sel;
    @(negedge clk);
    reg_rd  = 1'b0;
  endtask

  task automatic wr_entry(input logic [7:0] idx, input logic [23:0] rgb);
    wr(1'b0, idx);
    wr(1'b1, rgb[23:16]);
    wr(1'b1, rgb[15:8]);
    wr(1'b1, rgb[7:0]);
  endtask

  task automatic lookup(input string name, input logic [7:0] addr, input logic [23:0] exp);
    palette_addr = addr;
    @(negedge clk);
    check(name, pix, exp);
  endtask

  initial begin
    tbl[0]  = '{8'h10, 24'h112233};
    tbl[1]  = '{8'h11, 24'h445566};
    tbl[2]  = '{8'hFF, 24'h010203};
    tbl[3]  = '{8'h00, 24'hA1B2C3};
    tbl[4]  = '{8'h20, 24'hAABBCC};
    tbl[5]  = '{8'h30, 24'h010203};
    tbl[6]  = '{8'h40, 24'h123456};
    tbl[7]  = '{8'h41, 24'h0A0B0C};
    tbl[8]  = '{8'h50, 24'h010203};
    tbl[9]  = '{8'h60, 24'h0C0D0E};
    tbl[10] = '{8'h70, 24'h5A6B7C};

    repeat (3) @(negedge clk);
    check("reset_pix", pix, 24'h000000);
    check("reset_rdata", {16'h0, reg_rdata}, 24'h000000);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic load and one-clk lookup.
    wr_entry(8'h10, 24'h112233);
    lookup("case1_0x10", 8'h10, 24'h112233);

    // Index auto-incremented to 0x11 with phase back at R.
    wr(1'b1, 8'h44); wr(1'b1, 8'h55); wr(1'b1, 8'h66);
    lookup("autoinc_0x11", 8'h11, 24'h445566);

`ifdef VDP_SUPER_PALETTE_READBACK_EN
    wr(1'b0, 8'h10);
    rd(1'b1); check("rb_r", {16'h0, reg_rdata}, 24'h000011);
    rd(1'b1); check("rb_g", {16'h0, reg_rdata}, 24'h000022);
    rd(1'b1); check("rb_b", {16'h0, reg_rdata}, 24'h000033);
    rd(1'b0); check("rb_index", {16'h0, reg_rdata}, 24'h000011);
`endif

    // Index wrap from 0xFF to 0x00.
    wr(1'b0, 8'hFF);
    wr(1'b1, 8'h01); wr(1'b1, 8'h02); wr(1'b1, 8'h03);
    wr(1'b1, 8'h04); wr(1'b1, 8'h05); wr(1'b1, 8'h06);
    lookup("wrap_0xff", 8'hFF, 24'h010203);
    lookup("wrap_0x00", 8'h00, 24'h040506);

    // Commit while the video path reads the same entry.
    wr_entry(8'h20, 24'h000000);
    palette_addr = 8'h20;
    wr(1'b0, 8'h20);
    wr(1'b1, 8'hAA);
    wr(1'b1, 8'hBB);
    wr(1'b1, 8'hCC);
    check("collide_old", pix, 24'h000000);
    @(negedge clk);
    check("collide_new", pix, 24'hAABBCC);

    // Reset mid-sequence discards R/G and restarts index 0, phase R.
    wr(1'b0, 8'h30);
    wr(1'b1, 8'h77);
    wr(1'b1, 8'h88);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_pix", pix, 24'h000000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr(1'b1, 8'hA1); wr(1'b1, 8'hB2); wr(1'b1, 8'hC3);
    lookup("postreset_idx0", 8'h00, 24'hA1B2C3);
    wr_entry(8'h30, 24'h010203);
    lookup("postreset_0x30", 8'h30, 24'h010203);

    // Index write in the middle of a sequence.
    wr_entry(8'h40, 24'h123456);
    wr(1'b0, 8'h40);
    wr(1'b1, 8'h99);
    wr(1'b0, 8'h41);
    wr(1'b1, 8'h0A); wr(1'b1, 8'h0B); wr(1'b1, 8'h0C);
    lookup("midseq_0x41", 8'h41, 24'h0A0B0C);
    lookup("midseq_0x40", 8'h40, 24'h123456);

    // Gaps between data writes hold the phase.
    wr(1'b0, 8'h50);
    wr(1'b1, 8'h01);
    repeat (5) @(negedge clk);
    wr(1'b1, 8'h02);
    repeat (7) @(negedge clk);
    wr(1'b1, 8'h03);
    lookup("gap_0x50", 8'h50, 24'h010203);

`ifdef VDP_SUPER_PALETTE_READBACK_EN
    wr_entry(8'h60, 24'h0C0D0E);
`else
    // Reads have no effect on the sequencer without read-back.
    wr(1'b0, 8'h60);
    rd(1'b1);
    wr(1'b1, 8'h0C);
    rd(1'b1);
    wr(1'b1, 8'h0D);
    rd(1'b0);
    wr(1'b1, 8'h0E);
    check("noreadback_rdata", {16'h0, reg_rdata}, 24'h000000);
`endif
    lookup("rd_ignored_0x60", 8'h60, 24'h0C0D0E);

    // Simultaneous write and read: write happens, rdata holds.
    reg_rd = 1'b1;
    wr_entry(8'h70, 24'h5A6B7C);
    reg_rd = 1'b0;
`ifdef VDP_SUPER_PALETTE_READBACK_EN
    check("wr_rd_hold", {16'h0, reg_rdata}, 24'h000011);
`else
    check("wr_rd_zero", {16'h0, reg_rdata}, 24'h000000);
`endif
    lookup("wr_rd_0x70", 8'h70, 24'h5A6B7C);

    // Back-to-back lookups, a new address every clk.
    palette_addr = tbl[0].addr;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check($sformatf("sweep_%02h", tbl[i].addr), pix, tbl[i].rgb);
      if (i < 10) palette_addr = tbl[i+1].addr;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
